// File: rtl/spi_regbank_ctrl.sv
// Byte-level SPI transaction controller: decodes a R/W command byte and runs
// auto-incrementing register bursts over a 7-bit address / 8-bit data bus.
module spi_regbank_ctrl #(
    parameter logic [7:0] STATUS = 8'hA5,
    parameter logic       CPOL   = 1'b0,
    parameter logic       CPHA   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       cpol,
    output logic       cpha,
    input  logic       select,
    input  logic       start,
    input  logic       done,
    input  logic       busy,
    input  logic [7:0] dout,
    output logic [7:0] din,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       overrun,
    input  logic       clr_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_FETCH,
        RD_DATA
    } state_t;

    state_t     state_reg, state_next;
    logic       select_q_reg, start_q_reg, done_q_reg;
    logic [7:0] din_reg, din_next;
    logic [6:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       we_reg, we_next;
    logic       re_reg, re_next;
    logic       overrun_reg, overrun_next;
    logic       skip_reg, skip_next;
    logic       overrun_set;

    logic select_rise, start_rise, done_rise;

    assign select_rise = select & ~select_q_reg;
    assign start_rise  = start & ~start_q_reg;
    assign done_rise   = done & ~done_q_reg;

    always_comb begin
        state_next   = state_reg;
        din_next     = din_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        we_next      = 1'b0;
        re_next      = 1'b0;
        skip_next    = skip_reg;
        overrun_set  = 1'b0;

        // Post-write increment lands the cycle after the strobe.
        if (we_reg) begin
            addr_next = addr_reg + 7'd1;
        end

        case (state_reg)
            IDLE: begin
                din_next = STATUS;
                if (select_rise) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (done_rise) begin
                    addr_next = dout[6:0];
                    if (dout[7]) begin
                        re_next    = 1'b1;
                        skip_next  = 1'b0;
                        state_next = RD_FETCH;
                    end else begin
                        state_next = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (done_rise) begin
                    wdata_next = dout;
                    we_next    = 1'b1;
                end
            end
            RD_FETCH: begin
                // A byte that starts before the fetch lands is sent as 0xFF;
                // the late read data must not disturb din mid-byte.
                if (start_rise) begin
                    overrun_set = 1'b1;
                    skip_next   = 1'b1;
                    din_next    = 8'hFF;
                end
                if (!re_reg) begin
                    state_next = RD_DATA;
                    if (!(skip_reg || start_rise)) begin
                        din_next = reg_rdata;
                    end
                end
            end
            RD_DATA: begin
                if (done_rise) begin
                    addr_next  = addr_reg + 7'd1;
                    re_next    = 1'b1;
                    skip_next  = 1'b0;
                    state_next = RD_FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Deselect aborts everything except a write already captured this cycle.
        if (!select) begin
            state_next = IDLE;
            din_next   = STATUS;
            re_next    = 1'b0;
            skip_next  = 1'b0;
        end

        if (overrun_set) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            select_q_reg <= 1'b0;
            start_q_reg  <= 1'b0;
            done_q_reg   <= 1'b0;
            din_reg      <= STATUS;
            addr_reg     <= 7'd0;
            wdata_reg    <= 8'd0;
            we_reg       <= 1'b0;
            re_reg       <= 1'b0;
            overrun_reg  <= 1'b0;
            skip_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            select_q_reg <= select;
            start_q_reg  <= start;
            done_q_reg   <= done;
            din_reg      <= din_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            we_reg       <= we_next;
            re_reg       <= re_next;
            overrun_reg  <= overrun_next;
            skip_reg     <= skip_next;
        end
    end

    // busy is part of the shifter handshake but overrun is judged from start.
    logic busy_unused;
    assign busy_unused = busy;

    assign cpol      = CPOL;
    assign cpha      = CPHA;
    assign din       = din_reg;
    assign reg_addr  = addr_reg;
    assign reg_wdata = wdata_reg;
    assign reg_we    = we_reg;
    assign reg_re    = re_reg;
    assign overrun   = overrun_reg;

endmodule
